sfp_norm: RTL and testbench

//  Special-function stage directly downstream of the psum memory (pmem) in fullchip.

---
 rtl/sfp_norm.sv | 155 +++++++++++++++
 tb/tb_sfp_norm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_norm.sv
// sfp_norm: row normalizer downstream of pmem. Sums |x_i| over a col-wide row,
// then divides each lane's magnitude (scaled by 2^FRAC) by that sum with a
// bit-serial restoring divider and restores the lane's sign.
module sfp_norm #(
   parameter int bw_psum = 20,
   parameter int col     = 8,
   parameter int FRAC    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [bw_psum*col-1:0]   in_psum,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [bw_psum*col-1:0]   out_norm,
   output logic [bw_psum+2:0]       out_sum
);

   localparam int DW = bw_psum + FRAC;       // dividend width |x|<<FRAC
   localparam int SW = bw_psum + 3;          // sum width with log2(col) guard bits
   localparam int LW = $clog2(col + 1);      // lane counter reaches col
   localparam int CW = $clog2(DW);           // quotient bit counter

   typedef enum logic [1:0] {IDLE, SUM, DIV, OUT} state_t;

   state_t                  state;
   logic [bw_psum*col-1:0]  row;
   logic [SW-1:0]           sum;
   logic [DW-1:0]           dvd;
   logic [SW-1:0]           rem;
   logic [bw_psum-2:0]      quo;
   logic [LW-1:0]           lane;
   logic [CW-1:0]           bitn;

   // Magnitude in one extra bit so the most negative lane value is exact.
   function automatic logic [bw_psum:0] mag(input logic signed [bw_psum-1:0] x);
      logic signed [bw_psum:0] w;
      w = {x[bw_psum-1], x};
      return x[bw_psum-1] ? -w : w;
   endfunction

   function automatic logic signed [bw_psum-1:0] lane_of(input logic [bw_psum*col-1:0] r,
                                                        input int i);
      return r[i*bw_psum +: bw_psum];
   endfunction

   // Dividend for lane i: |x_i| shifted up by FRAC fractional bits.
   function automatic logic [DW-1:0] dvd_of(input logic [bw_psum*col-1:0] r, input int i);
      logic [bw_psum:0] m;
      m = mag(lane_of(r, i));
      return DW'(m) << FRAC;
   endfunction

   int                      cur_idx;
   logic [bw_psum:0]        cur_mag;
   logic                    neg;
   logic [SW:0]             trial;
   logic                    fits;
   logic [SW-1:0]           rem_nx;
   logic [bw_psum-1:0]      q_nx;
   logic signed [bw_psum-1:0] y;

   // One restoring-division step plus the current lane's magnitude and sign.
   always_comb begin
      cur_idx = (lane < LW'(col)) ? int'(lane) : 0;
      cur_mag = mag(lane_of(row, cur_idx));
      neg     = row[cur_idx*bw_psum + bw_psum - 1];
      trial   = {rem, dvd[DW-1]};
      fits    = (trial >= {1'b0, sum});
      rem_nx  = fits ? SW'(trial - {1'b0, sum}) : trial[SW-1:0];
      q_nx    = {quo, fits};
      y       = neg ? -$signed(q_nx) : $signed(q_nx);
   end

   assign out_sum = sum;

   // Control FSM and datapath: accept, accumulate, divide lane by lane, hold output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         row       <= '0;
         sum       <= '0;
         dvd       <= '0;
         rem       <= '0;
         quo       <= '0;
         lane      <= '0;
         bitn      <= '0;
         out_norm  <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  row      <= in_psum;
                  sum      <= '0;
                  lane     <= '0;
                  out_norm <= '0;
                  in_ready <= 1'b0;
                  state    <= SUM;
               end
            end
            SUM: begin
               if (lane == LW'(col)) begin
                  // A zero sum leaves every lane at the zero cleared on accept.
                  if (sum == '0) begin
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end else begin
                     lane  <= '0;
                     dvd   <= dvd_of(row, 0);
                     rem   <= '0;
                     quo   <= '0;
                     bitn  <= '0;
                     state <= DIV;
                  end
               end else begin
                  sum  <= sum + SW'(cur_mag);
                  lane <= lane + 1'b1;
               end
            end
            DIV: begin
               rem  <= rem_nx;
               quo  <= q_nx[bw_psum-2:0];
               dvd  <= dvd << 1;
               bitn <= bitn + 1'b1;
               if (bitn == CW'(DW - 1)) begin
                  out_norm[int'(lane)*bw_psum +: bw_psum] <= y;
                  rem  <= '0;
                  quo  <= '0;
                  bitn <= '0;
                  if (lane == LW'(col - 1)) begin
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end else begin
                     lane <= lane + 1'b1;
                     dvd  <= dvd_of(row, int'(lane) + 1);
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfp_norm.sv
// Bench for sfp_norm: expected rows from an integer model go into a scoreboard
// queue on accept and are compared when the row appears on the output.
module tb_sfp_norm;

   localparam int BW   = 20;
   localparam int COL  = 8;
   localparam int FRAC = 8;
   localparam int DW   = BW + FRAC;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [BW*COL-1:0]    in_psum;
   logic                 out_valid;
   logic                 out_ready;
   logic [BW*COL-1:0]    out_norm;
   logic [BW+2:0]        out_sum;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [BW*COL-1:0] norm;
      logic [BW+2:0]     sum;
      int                lat;
   } exp_t;

   exp_t sb[$];

   sfp_norm #(.bw_psum(BW), .col(COL), .FRAC(FRAC)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_psum(in_psum), .out_valid(out_valid), .out_ready(out_ready),
      .out_norm(out_norm), .out_sum(out_sum)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [BW*COL-1:0] r);
      exp_t   e;
      longint s;
      longint x;
      longint q;
      s = 0;
      e.norm = '0;
      for (int i = 0; i < COL; i++) begin
         x = longint'(signed'(r[i*BW +: BW]));
         s += (x < 0) ? -x : x;
      end
      for (int i = 0; i < COL; i++) begin
         x = longint'(signed'(r[i*BW +: BW]));
         if (s == 0) q = 0;
         else q = (((x < 0) ? -x : x) * (64'sd1 << FRAC)) / s;
         if (x < 0) q = -q;
         e.norm[i*BW +: BW] = q[BW-1:0];
      end
      e.sum = s[BW+2:0];
      e.lat = (s == 0) ? (1 + COL) : (1 + COL + COL*DW);
      return e;
   endfunction

   function automatic logic [BW*COL-1:0] mkrow(input int v0, input int v1, input int v2,
                                               input int v3, input int v4, input int v5,
                                               input int v6, input int v7);
      logic [BW*COL-1:0] r;
      r[0*BW +: BW] = v0[BW-1:0]; r[1*BW +: BW] = v1[BW-1:0];
      r[2*BW +: BW] = v2[BW-1:0]; r[3*BW +: BW] = v3[BW-1:0];
      r[4*BW +: BW] = v4[BW-1:0]; r[5*BW +: BW] = v5[BW-1:0];
      r[6*BW +: BW] = v6[BW-1:0]; r[7*BW +: BW] = v7[BW-1:0];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [BW*COL-1:0] r);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      end
      in_psum  = r;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      sb.push_back(model(r));
   endtask

   task automatic receive(input string name, input int hold);
      exp_t e;
      int   n;
      n = 0;
      while (!out_valid && n < 400) begin
         tick();
         n++;
      end
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb: scoreboard empty", name);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin
         failures++;
         $display("FAIL %s_lat: out_valid after %0d edges, required %0d", name, n, e.lat);
      end
      checks++;
      if (out_norm !== e.norm) begin
         failures++;
         $display("FAIL %s_norm: got %h required %h", name, out_norm, e.norm);
      end
      checks++;
      if (out_sum !== e.sum) begin
         failures++;
         $display("FAIL %s_sum: got %0d required %0d", name, out_sum, e.sum);
      end
      for (int k = 0; k < hold; k++) begin
         in_psum  = mkrow(7, 7, 7, 7, 7, 7, 7, 7);
         in_valid = k[0];
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_norm !== e.norm || out_sum !== e.sum) begin
            failures++;
            $display("FAIL %s_hold: cycle %0d out_valid=%0b in_ready=%0b sum=%0d required 1/0/%0d",
                     name, k, out_valid, in_ready, out_sum, e.sum);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_psum   = '0;
      repeat (3) tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_norm !== '0 || out_sum !== '0) begin
         failures++;
         $display("FAIL reset_state: in_ready=%0b out_valid=%0b sum=%0d required 0/0/0",
                  in_ready, out_valid, out_sum);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      send(mkrow(8, -8, 0, 0, 0, 0, 0, 0));
      receive("pm8", 0);
      send(mkrow(0, 0, 0, 100, 0, 0, 0, 0));
      receive("lane3", 0);
   endtask

   task automatic test_zero();
      send(mkrow(0, 0, 0, 0, 0, 0, 0, 0));
      receive("zero", 0);
   endtask

   task automatic test_extremes();
      send(mkrow(-524288, 0, 0, 0, 0, 0, 0, 0));
      receive("minval", 0);
      send(mkrow(1, 2, 0, 0, 0, 0, 0, 0));
      receive("trunc", 0);
      send(mkrow(524287, -524288, 524287, -524288, 524287, -524288, 524287, -524288));
      receive("fullscale", 0);
   endtask

   task automatic test_backpressure();
      send(mkrow(3, -5, 11, 0, -1, 2, 0, 9));
      receive("hold", 5);
      send(mkrow(-20, 0, 0, 40, 0, 0, 0, 0));
      receive("after_hold", 0);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         logic [BW*COL-1:0] r;
         for (int i = 0; i < COL; i++)
            r[i*BW +: BW] = BW'($urandom_range(0, 2000) - 1000);
         send(r);
         receive("b2b", 0);
      end
   endtask

   task automatic test_reset_mid();
      exp_t drop;
      send(mkrow(100, -37, 5, 0, 0, 0, 0, 1));
      repeat (99) tick();
      reset = 1'b0;
      #1;
      drop = sb.pop_back();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_norm !== '0 || out_sum !== '0) begin
         failures++;
         $display("FAIL midreset_state: out_valid=%0b in_ready=%0b sum=%0d required 0/0/0 (dropped sum %0d)",
                  out_valid, in_ready, out_sum, drop.sum);
      end
      repeat (2) tick();
      reset = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
      end
      send(mkrow(0, 6, -6, 0, 12, 0, 0, 0));
      receive("post_reset", 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_extremes();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
